aes_wb_tracker: RTL and testbench

In-order writeback tracker for the AES32 scalar coprocessor. It queues one `id_rd_packet_t` per issued AES32 instruction (AES32ESI, AES32ESMI, AES32DSI, AES32DSMI). It pairs each 32-bit result coming back from the AES datapath with the oldest queued packet. It drives the register-file writeback towards the core and silently discards results whose instruction was killed or targets x0. It sits between the decode/issue stage and the core writeback port.

---
 rtl/aes_wb_tracker.sv | 154 +++++++++++++++
 tb/tb_aes_wb_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_wb_tracker.sv
// In-order writeback tracker for the AES32 coprocessor: queues issued packets,
// pairs returning results with the oldest one, and drives core writeback.

module aes_wb_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [3:0] wr_id,
  input  logic [4:0] wr_rd,
  input  logic       wr_kill,
  input  logic       clr,
  input  logic       kill_valid,
  input  logic [3:0] kill_id,
  output logic [3:0] id,
  output logic [4:0] rd,
  output logic       kill
);
  logic vld;

  // A slot is never written and cleared in the same cycle: push needs a free
  // slot, pop needs an occupied one.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      id   <= '0;
      rd   <= '0;
      kill <= 1'b0;
    end else if (wr) begin
      vld  <= 1'b1;
      id   <= wr_id;
      rd   <= wr_rd;
      kill <= wr_kill;
    end else begin
      if (clr) begin
        vld  <= 1'b0;
        kill <= 1'b0;
      end else if (kill_valid && vld && id == kill_id) begin
        kill <= 1'b1;
      end
    end
  end
endmodule

module aes_wb_tracker #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [9:0]                 issue_pkt_i,
  input  logic                       kill_valid_i,
  input  logic [3:0]                 kill_id_i,
  input  logic                       res_valid_i,
  input  logic [31:0]                res_data_i,
  output logic                       res_ready_o,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [4:0]                 wb_rd_adr_o,
  output logic [31:0]                wb_data_o,
  output logic [3:0]                 wb_instr_id_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       err_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0] instr_id;
    logic [4:0] rd_adr;
    logic       kill;
  } id_rd_packet_t;

  id_rd_packet_t pkt_in;
  assign pkt_in = issue_pkt_i;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, empty, push, pop;

  logic [DEPTH-1:0][3:0] slot_id;
  logic [DEPTH-1:0][4:0] slot_rd;
  logic [DEPTH-1:0]      slot_kill;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign issue_ready_o = !full;
  assign res_ready_o   = !empty && (!wb_valid_o || wb_ready_i);
  assign push          = issue_valid_i && !full;
  assign pop           = res_valid_i && res_ready_o;
  assign outstanding_o = count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    aes_wb_slot u_slot (
      .clk        (clk_i),
      .rst        (rst_i),
      .wr         (push && wr_ptr == PW'(g)),
      .wr_id      (pkt_in.instr_id),
      .wr_rd      (pkt_in.rd_adr),
      .wr_kill    (pkt_in.kill),
      .clr        (pop && rd_ptr == PW'(g)),
      .kill_valid (kill_valid_i),
      .kill_id    (kill_id_i),
      .id         (slot_id[g]),
      .rd         (slot_rd[g]),
      .kill       (slot_kill[g])
    );
  end

  logic [3:0] head_id;
  logic [4:0] head_rd;
  logic       head_kill, deliver;

  assign head_id   = slot_id[rd_ptr];
  assign head_rd   = slot_rd[rd_ptr];
  // A kill arriving in the pop cycle still discards the head's result.
  assign head_kill = slot_kill[rd_ptr] || (kill_valid_i && kill_id_i == head_id);
  assign deliver   = pop && !head_kill && (head_rd != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_adr_o   <= '0;
      wb_data_o     <= '0;
      wb_instr_id_o <= '0;
      err_o         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (deliver) begin
        wb_valid_o    <= 1'b1;
        wb_rd_adr_o   <= head_rd;
        wb_data_o     <= res_data_i;
        wb_instr_id_o <= head_id;
      end else if (wb_valid_o && wb_ready_i) begin
        wb_valid_o    <= 1'b0;
        wb_rd_adr_o   <= '0;
        wb_data_o     <= '0;
        wb_instr_id_o <= '0;
      end

      if ((res_valid_i && empty) || (issue_valid_i && full)) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_wb_tracker.sv
// Directed bench for aes_wb_tracker: hand-computed expectations per scenario.

module tb_aes_wb_tracker;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [9:0]  issue_pkt;
  logic        kill_valid;
  logic [3:0]  kill_id;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  wb_id;
  logic [2:0]  outstanding;
  logic        err;

  int n = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_wb_tracker #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_pkt_i(issue_pkt),
    .kill_valid_i(kill_valid), .kill_id_i(kill_id),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_adr_o(wb_rd),
    .wb_data_o(wb_data), .wb_instr_id_o(wb_id),
    .outstanding_o(outstanding), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; issue_valid = 1'b0; kill_valid = 1'b0; res_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    issue_pkt = '0; kill_id = '0; res_data = '0; wb_ready = 1'b1;
    do_reset();
    tick();
    n++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready: got %0h want 1", issue_ready); end
    n++; if (res_ready !== 1'b0) begin fails++; $display("FAIL reset_res_ready: got %0h want 0", res_ready); end
    n++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid: got %0h want 0", wb_valid); end
    n++; if ({wb_rd, wb_data, wb_id} !== 41'h0) begin fails++; $display("FAIL reset_wb_fields: got %0h want 0", {wb_rd, wb_data, wb_id}); end
    n++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0h want 0", err); end
  endtask

  task automatic test_single();
    issue_valid = 1'b1; issue_pkt = {4'd1, 5'd5, 1'b0};
    tick();
    issue_valid = 1'b0;
    n++; if (outstanding !== 3'd1) begin fails++; $display("FAIL single_occ1: got %0d want 1", outstanding); end
    n++; if (res_ready !== 1'b1) begin fails++; $display("FAIL single_res_ready: got %0h want 1", res_ready); end
    res_valid = 1'b1; res_data = 32'hDEADBEEF;
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, wb_rd, wb_data, wb_id} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd1})
      begin fails++; $display("FAIL single_wb: got %0h want %0h", {wb_valid, wb_rd, wb_data, wb_id}, {1'b1, 5'd5, 32'hDEADBEEF, 4'd1}); end
    n++; if (outstanding !== 3'd0) begin fails++; $display("FAIL single_occ0: got %0d want 0", outstanding); end
    tick();
    n++; if ({wb_valid, wb_rd, wb_data, wb_id} !== 42'h0) begin fails++; $display("FAIL single_handoff: got %0h want 0", {wb_valid, wb_rd, wb_data, wb_id}); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_pkt = {4'(i), 5'(i + 1), 1'b0};
      tick();
    end
    n++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0h want 0", issue_ready); end
    n++; if (outstanding !== 3'd4) begin fails++; $display("FAIL full_occ: got %0d want 4", outstanding); end
    n++; if (err !== 1'b0) begin fails++; $display("FAIL full_err_early: got %0h want 0", err); end
    issue_pkt = {4'd9, 5'd9, 1'b0};
    tick();
    issue_valid = 1'b0;
    n++; if (err !== 1'b1) begin fails++; $display("FAIL full_overflow_err: got %0h want 1", err); end
    n++; if (outstanding !== 3'd4) begin fails++; $display("FAIL full_overflow_occ: got %0d want 4", outstanding); end
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = 32'hA0 + 32'(i);
      tick();
      n++; if ({wb_valid, wb_rd, wb_data, wb_id} !== {1'b1, 5'(i + 1), 32'hA0 + 32'(i), 4'(i)})
        begin fails++; $display("FAIL full_drain%0d: got %0h want %0h", i, {wb_valid, wb_rd, wb_data, wb_id}, {1'b1, 5'(i + 1), 32'hA0 + 32'(i), 4'(i)}); end
    end
    res_valid = 1'b0;
    tick();
    n++; if ({wb_valid, outstanding} !== 4'h0) begin fails++; $display("FAIL full_empty: got %0h want 0", {wb_valid, outstanding}); end
    do_reset();
    n++; if (err !== 1'b0) begin fails++; $display("FAIL full_err_clear: got %0h want 0", err); end
  endtask

  task automatic test_kill();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_pkt = {4'(i + 2), 5'(i + 7), 1'b0};
      tick();
    end
    issue_valid = 1'b0; kill_valid = 1'b1; kill_id = 4'd3;
    tick();
    kill_valid = 1'b0;
    res_valid = 1'b1; res_data = 32'h100;
    tick();
    n++; if ({wb_valid, wb_rd, wb_data, wb_id} !== {1'b1, 5'd7, 32'h100, 4'd2})
      begin fails++; $display("FAIL kill_wb_id2: got %0h want %0h", {wb_valid, wb_rd, wb_data, wb_id}, {1'b1, 5'd7, 32'h100, 4'd2}); end
    res_data = 32'h101;
    tick();
    n++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL kill_dropped_id3: got %0h want 0", wb_valid); end
    res_data = 32'h102;
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, wb_rd, wb_data, wb_id} !== {1'b1, 5'd9, 32'h102, 4'd4})
      begin fails++; $display("FAIL kill_wb_id4: got %0h want %0h", {wb_valid, wb_rd, wb_data, wb_id}, {1'b1, 5'd9, 32'h102, 4'd4}); end
    n++; if (outstanding !== 3'd0) begin fails++; $display("FAIL kill_occ: got %0d want 0", outstanding); end
    tick();
  endtask

  task automatic test_drop();
    issue_valid = 1'b1; issue_pkt = {4'd5, 5'd0, 1'b0};
    tick();
    issue_pkt = {4'd6, 5'd3, 1'b1};
    tick();
    issue_valid = 1'b0;
    res_valid = 1'b1; res_data = 32'h200;
    tick();
    n++; if ({wb_valid, outstanding} !== {1'b0, 3'd1}) begin fails++; $display("FAIL drop_x0: got %0h want 1", {wb_valid, outstanding}); end
    res_data = 32'h201;
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, outstanding} !== {1'b0, 3'd0}) begin fails++; $display("FAIL drop_killed: got %0h want 0", {wb_valid, outstanding}); end
    n++; if (err !== 1'b0) begin fails++; $display("FAIL drop_err: got %0h want 0", err); end
  endtask

  task automatic test_concurrent();
    issue_valid = 1'b1; issue_pkt = {4'd1, 5'd5, 1'b0};
    tick();
    issue_pkt = {4'd2, 5'd6, 1'b0}; res_valid = 1'b1; res_data = 32'h55;
    tick();
    n++; if ({outstanding, wb_valid, wb_id, wb_data} !== {3'd1, 1'b1, 4'd1, 32'h55})
      begin fails++; $display("FAIL conc_push_pop: got %0h want %0h", {outstanding, wb_valid, wb_id, wb_data}, {3'd1, 1'b1, 4'd1, 32'h55}); end
    // kill of the packet being pushed this cycle must not stick
    issue_pkt = {4'd3, 5'd7, 1'b0}; kill_valid = 1'b1; kill_id = 4'd3; res_data = 32'h66;
    tick();
    issue_valid = 1'b0; kill_valid = 1'b0; res_data = 32'h77;
    n++; if ({outstanding, wb_valid, wb_id, wb_data} !== {3'd1, 1'b1, 4'd2, 32'h66})
      begin fails++; $display("FAIL conc_id2: got %0h want %0h", {outstanding, wb_valid, wb_id, wb_data}, {3'd1, 1'b1, 4'd2, 32'h66}); end
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, wb_rd, wb_id, wb_data} !== {1'b1, 5'd7, 4'd3, 32'h77})
      begin fails++; $display("FAIL conc_push_kill_ignored: got %0h want %0h", {wb_valid, wb_rd, wb_id, wb_data}, {1'b1, 5'd7, 4'd3, 32'h77}); end
    issue_valid = 1'b1; issue_pkt = {4'd7, 5'd4, 1'b0};
    tick();
    issue_valid = 1'b0; res_valid = 1'b1; res_data = 32'h88; kill_valid = 1'b1; kill_id = 4'd7;
    tick();
    res_valid = 1'b0; kill_valid = 1'b0;
    n++; if ({wb_valid, outstanding} !== 4'h0) begin fails++; $display("FAIL conc_head_kill: got %0h want 0", {wb_valid, outstanding}); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    issue_valid = 1'b1; issue_pkt = {4'd8, 5'd10, 1'b0};
    tick();
    issue_pkt = {4'd9, 5'd11, 1'b0};
    tick();
    issue_valid = 1'b0; res_valid = 1'b1; res_data = 32'h11111111;
    tick();
    res_data = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      n++; if (res_ready !== 1'b0) begin fails++; $display("FAIL bp_res_ready%0d: got %0h want 0", i, res_ready); end
      n++; if ({wb_valid, wb_rd, wb_data, wb_id, outstanding} !== {1'b1, 5'd10, 32'h11111111, 4'd8, 3'd1})
        begin fails++; $display("FAIL bp_stable%0d: got %0h want %0h", i, {wb_valid, wb_rd, wb_data, wb_id, outstanding}, {1'b1, 5'd10, 32'h11111111, 4'd8, 3'd1}); end
      tick();
    end
    wb_ready = 1'b1;
    #1;
    n++; if (res_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0h want 1", res_ready); end
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, wb_rd, wb_data, wb_id, outstanding} !== {1'b1, 5'd11, 32'h22222222, 4'd9, 3'd0})
      begin fails++; $display("FAIL bp_second: got %0h want %0h", {wb_valid, wb_rd, wb_data, wb_id, outstanding}, {1'b1, 5'd11, 32'h22222222, 4'd9, 3'd0}); end
    tick();
    n++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL bp_done: got %0h want 0", wb_valid); end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_pkt = {4'(i + 10), 5'(i + 1), 1'b0};
      tick();
    end
    issue_valid = 1'b0; res_valid = 1'b1; res_data = 32'h99;
    tick();
    res_valid = 1'b0;
    n++; if ({wb_valid, outstanding} !== {1'b1, 3'd3}) begin fails++; $display("FAIL mid_pre: got %0h want b", {wb_valid, outstanding}); end
    do_reset();
    n++; if ({issue_ready, res_ready, wb_valid, outstanding, err} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0})
      begin fails++; $display("FAIL mid_reset_ctl: got %0h want %0h", {issue_ready, res_ready, wb_valid, outstanding, err}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); end
    n++; if ({wb_rd, wb_data, wb_id} !== 41'h0) begin fails++; $display("FAIL mid_reset_fields: got %0h want 0", {wb_rd, wb_data, wb_id}); end
    wb_ready = 1'b1; res_valid = 1'b1; res_data = 32'hAB;
    tick();
    res_valid = 1'b0;
    n++; if ({err, wb_valid, outstanding} !== {1'b1, 1'b0, 3'd0}) begin fails++; $display("FAIL mid_underflow: got %0h want 10", {err, wb_valid, outstanding}); end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; kill_valid = 1'b0; res_valid = 1'b0; wb_ready = 1'b1;
    issue_pkt = '0; kill_id = '0; res_data = '0;
    test_reset();
    test_single();
    test_full();
    test_kill();
    test_drop();
    test_concurrent();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
